snn_timestep_sequencer: RTL and testbench
=========================================

// Module: snn_timestep_sequencer
// PURPOSE
// Hardware replacement for the bench-driven timestep loop around snn_ecg_net_parallel.
// On cmd_start it runs num_steps timesteps. Each timestep proceeds as follows:
//   - fetch one packed input-spike word from a synchronous stimulus RAM;
//   - present the word to the network and pulse net_start;
//   - wait for net_done;
//   - accumulate the output spikes into per-class counters.
// After the last step it reports the per-class counts and the argmax class.
// PARAMETERS
// N_IN     30   input spike bits per timestep (stimulus word width)
// N_OUT    5    output neurons / classes
// CNT_W    8    per-class spike counter width (saturating)
// STEP_W   8    timestep index width; stimulus address width
// TMO_W    10   width of the net_done watchdog counter; timeout = 2**TMO_W-1 cycles
// PORTS
// clk            in   1            system clock, rising edge
// rst            in   1            asynchronous reset, active-high
// cmd_start      in   1            request a run; sampled only in IDLE
// num_steps      in   STEP_W       timesteps to run; captured when cmd_start is accepted
// stim_rd_en     out  1            stimulus RAM read strobe
// stim_addr      out  STEP_W       stimulus RAM address (= current timestep index)
// stim_data      in   N_IN         RAM read data, valid 1 cycle after stim_rd_en
// net_start      out  1            one-cycle launch pulse to the network
// net_spikes_in  out  N_IN         input spikes to the network; held stable LAUNCH..done
// net_done       in   1            network timestep complete (level or pulse)
// net_spikes_out in   N_OUT        network output spikes; valid while net_done=1
// busy           out  1            run in progress
// result_valid   out  1            results valid; level
// result_class   out  3            argmax of counts; ties resolve to the lowest index
// result_counts  out  N_OUT*CNT_W  packed counts; class k at [k*CNT_W +: CNT_W]
// result_err     out  1            run aborted by watchdog
// BEHAVIOUR
// Reset: async; all outputs and registers go to 0 and the FSM goes to IDLE.
//   Reset mid-run aborts immediately, with no result.
// FSM and per-state actions:
//   IDLE:   if cmd_start, then:
//           - latch num_steps;
//           - clear step, counters, result_valid, result_err and result_*;
//           - set busy;
//           - go to FETCH (or to ARGMAX if num_steps==0).
//   FETCH:  stim_rd_en=1, stim_addr=step; go to LOAD.
//   LOAD:   net_spikes_in <= stim_data; clear the watchdog; go to LAUNCH.
//   LAUNCH: net_start=1 for exactly this cycle; go to WAIT.
//   WAIT:   net_done is ignored in the LAUNCH cycle and first sampled here.
//           - On net_done=1: cnt[k] += net_spikes_out[k], saturating at 2**CNT_W-1;
//             step++; go to ARGMAX if step+1==num_steps, else go to FETCH.
//           - Else the watchdog increments. At all-ones, set result_err and go to
//             ARGMAX with the counts accumulated so far.
//   ARGMAX: scan counts with strict '>' so the lowest index wins ties; register
//           result_class and result_counts; set result_valid, clear busy; go to IDLE.
// Handshake and timing:
//   - Per-timestep cost = 3 + W cycles, where W (W>=1) is the WAIT cycles
//     including the net_done cycle.
//   - net_spikes_in changes only in LOAD; it holds its last value in IDLE.
//   - stim_rd_en and net_start are 0 in every state other than FETCH and LAUNCH.
//   - A level net_done still high from the previous step is never seen as done,
//     because it is sampled only in WAIT, which is entered after a new net_start.
//     The network drops done on start.
//   - cmd_start while busy is ignored, with no queueing.
//   - result_valid, result_* and result_err hold until the next accepted cmd_start.
//   - num_steps is captured at start, so changes during a run have no effect.
//   - Maximum run length is 2**STEP_W-1 steps; step never wraps within a run.
//   - num_steps==0: IDLE -> ARGMAX; result_valid with counts 0, class 0, err 0.
// TESTING
// 1) RAM[0..3]={bit0, bit1, bit0, 0}; net model echoes in[4:0] after 2 cycles;
//    num_steps=4 -> counts=[2,1,0,0,0], class=0, err=0.
// 2) Tie: net outputs 5'b00110 every step, num_steps=3 -> counts=[0,3,3,0,0], class=1.
// 3) Saturation: net outputs 5'b10000 every step, num_steps=255, CNT_W=4
//    -> cnt4=15, class=4.
// 4) net_done never asserted -> result_err=1 exactly 2**TMO_W-1 WAIT cycles after
//    net_start; busy drops; counts equal the completed steps.
// 5) num_steps=0 -> result_valid 2 cycles after cmd_start; counts 0; no net_start issued.
// 6) cmd_start pulsed while busy -> ignored. Assert rst mid-WAIT -> all outputs 0
//    asynchronously; a new run after reset produces correct results.
//    Checker throughout: one net_start per step; net_spikes_in stable LAUNCH..done.

Source files
------------

// File: rtl/snn_timestep_sequencer.sv
// ============================================================================
// snn_timestep_sequencer: runs N timesteps of the SNN, accumulates class
// spike counts and reports the argmax class.          Rev 1.0
// ============================================================================
`default_nettype none

module snn_timestep_sequencer #(
  parameter int N_IN   = 30,
  parameter int N_OUT  = 5,
  parameter int CNT_W  = 8,
  parameter int STEP_W = 8,
  parameter int TMO_W  = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_start,
  input  logic [STEP_W-1:0]      num_steps,
  output logic                   stim_rd_en,
  output logic [STEP_W-1:0]      stim_addr,
  input  logic [N_IN-1:0]        stim_data,
  output logic                   net_start,
  output logic [N_IN-1:0]        net_spikes_in,
  input  logic                   net_done,
  input  logic [N_OUT-1:0]       net_spikes_out,
  output logic                   busy,
  output logic                   result_valid,
  output logic [2:0]             result_class,
  output logic [N_OUT*CNT_W-1:0] result_counts,
  output logic                   result_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_LAUNCH = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_ARGMAX = 3'd5;

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
  localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);

  logic [2:0]                   state_q, state_d;
  logic [STEP_W-1:0]            steps_q, steps_d;
  logic [STEP_W-1:0]            step_q, step_d;
  logic [N_OUT-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]             wdog_q, wdog_d;
  logic [N_IN-1:0]              spikes_q, spikes_d;
  logic                         busy_q, busy_d;
  logic                         valid_q, valid_d;
  logic                         err_q, err_d;
  logic [2:0]                   class_q, class_d;
  logic [N_OUT*CNT_W-1:0]       counts_q, counts_d;

  logic [STEP_W-1:0]            step_inc;
  logic [TMO_W-1:0]             wdog_inc;
  logic                         last_step;
  logic                         wdog_expire;
  logic [2:0]                   best_idx;
  logic [CNT_W-1:0]             best_val;

  assign step_inc    = step_q + STEP_ONE;
  assign wdog_inc    = wdog_q + TMO_ONE;
  assign last_step   = (step_inc == steps_q);
  assign wdog_expire = (wdog_inc == {TMO_W{1'b1}});

  // Strict '>' keeps the lowest index on ties.
  always_comb begin
    best_idx = 3'd0;
    best_val = cnt_q[0];
    for (int k = 1; k < N_OUT; k++) begin
      if (cnt_q[k] > best_val) begin
        best_val = cnt_q[k];
        best_idx = 3'(k);
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          state_d = (num_steps == '0) ? S_ARGMAX : S_FETCH;
        end
      end
      S_FETCH:  state_d = S_LOAD;
      S_LOAD:   state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (net_done) begin
          state_d = last_step ? S_ARGMAX : S_FETCH;
        end else if (wdog_expire) begin
          state_d = S_ARGMAX;
        end
      end
      S_ARGMAX: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    stim_rd_en = (state_q == S_FETCH);
    net_start  = (state_q == S_LAUNCH);
  end

  always_comb begin
    steps_d  = steps_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    wdog_d   = wdog_q;
    spikes_d = spikes_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    err_d    = err_q;
    class_d  = class_q;
    counts_d = counts_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          steps_d  = num_steps;
          step_d   = '0;
          cnt_d    = '0;
          wdog_d   = '0;
          valid_d  = 1'b0;
          err_d    = 1'b0;
          class_d  = 3'd0;
          counts_d = '0;
          busy_d   = 1'b1;
        end
      end
      S_LOAD: begin
        spikes_d = stim_data;
        wdog_d   = '0;
      end
      S_WAIT: begin
        if (net_done) begin
          for (int k = 0; k < N_OUT; k++) begin
            if (net_spikes_out[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
              cnt_d[k] = cnt_q[k] + CNT_ONE;
            end
          end
          step_d = step_inc;
        end else begin
          wdog_d = wdog_inc;
          if (wdog_expire) begin
            err_d = 1'b1;
          end
        end
      end
      S_ARGMAX: begin
        class_d  = best_idx;
        counts_d = cnt_q;
        valid_d  = 1'b1;
        busy_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      steps_q  <= '0;
      step_q   <= '0;
      cnt_q    <= '0;
      wdog_q   <= '0;
      spikes_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      class_q  <= 3'd0;
      counts_q <= '0;
    end else begin
      steps_q  <= steps_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
      wdog_q   <= wdog_d;
      spikes_q <= spikes_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      class_q  <= class_d;
      counts_q <= counts_d;
    end
  end

  assign stim_addr     = step_q;
  assign net_spikes_in = spikes_q;
  assign busy          = busy_q;
  assign result_valid  = valid_q;
  assign result_err    = err_q;
  assign result_class  = class_q;
  assign result_counts = counts_q;

endmodule

`default_nettype wire

// File: tb/tb_snn_timestep_sequencer.sv
// ============================================================================
// tb_snn_timestep_sequencer: directed runs against a stimulus RAM and a
// behavioural network model, checked through an expected-result queue. Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_snn_timestep_sequencer;

  localparam int N_IN   = 30;
  localparam int N_OUT  = 5;
  localparam int CNT_W  = 4;
  localparam int STEP_W = 8;
  localparam int TMO_W  = 10;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   cmd_start;
  logic [STEP_W-1:0]      num_steps;
  logic                   stim_rd_en;
  logic [STEP_W-1:0]      stim_addr;
  logic [N_IN-1:0]        stim_data = '0;
  logic                   net_start;
  logic [N_IN-1:0]        net_spikes_in;
  logic                   net_done;
  logic [N_OUT-1:0]       net_spikes_out;
  logic                   busy;
  logic                   result_valid;
  logic [2:0]             result_class;
  logic [N_OUT*CNT_W-1:0] result_counts;
  logic                   result_err;

  snn_timestep_sequencer #(
    .N_IN(N_IN), .N_OUT(N_OUT), .CNT_W(CNT_W), .STEP_W(STEP_W), .TMO_W(TMO_W)
  ) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .num_steps(num_steps),
    .stim_rd_en(stim_rd_en), .stim_addr(stim_addr), .stim_data(stim_data),
    .net_start(net_start), .net_spikes_in(net_spikes_in), .net_done(net_done),
    .net_spikes_out(net_spikes_out), .busy(busy), .result_valid(result_valid),
    .result_class(result_class), .result_counts(result_counts), .result_err(result_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Synchronous stimulus RAM, one cycle read latency
  logic [N_IN-1:0] ram [0:255];
  always @(posedge clk) begin
    if (stim_rd_en) stim_data <= ram[stim_addr];
  end

  // Network model: drops done on start, raises level done net_lat cycles later
  int             net_lat    = 1;
  int             resp_limit = 1000;
  logic           net_mode   = 1'b0;
  logic [4:0]     net_pat    = '0;
  int             dly;
  int             resp_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      net_done       <= 1'b0;
      net_spikes_out <= '0;
      dly            <= 0;
      resp_cnt       <= 0;
    end else begin
      if (cmd_start && !busy) resp_cnt <= 0;
      if (net_start) begin
        net_done       <= 1'b0;
        net_spikes_out <= 5'h1F;
        dly            <= (resp_cnt < resp_limit) ? net_lat : 0;
        resp_cnt       <= resp_cnt + 1;
      end else if (dly != 0) begin
        dly <= dly - 1;
        if (dly == 1) begin
          net_done       <= 1'b1;
          net_spikes_out <= net_mode ? net_pat : net_spikes_in[4:0];
        end
      end
    end
  end

  typedef struct {
    logic [N_OUT*CNT_W-1:0] counts;
    logic [2:0]             cls;
    logic                   err;
    int                     starts;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  // Monitor: protocol tracking plus scoreboard compare on result_valid rise
  int              cyc = 0;
  int              starts = 0;
  int              last_start_cyc = 0;
  int              err_delta = -1;
  logic            prev_valid = 1'b0;
  logic            prev_err = 1'b0;
  logic            prev_start = 1'b0;
  logic            dbl_start = 1'b0;
  logic            in_flight = 1'b0;
  logic            stable_bad = 1'b0;
  logic [N_IN-1:0] held = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      starts = 0; prev_valid = 1'b0; prev_err = 1'b0; prev_start = 1'b0;
      dbl_start = 1'b0; in_flight = 1'b0; stable_bad = 1'b0;
    end else begin
      if (net_start) begin
        starts++;
        last_start_cyc = cyc;
        if (prev_start) dbl_start = 1'b1;
        in_flight  = 1'b1;
        held       = net_spikes_in;
        stable_bad = 1'b0;
      end else if (in_flight) begin
        if (net_spikes_in !== held) stable_bad = 1'b1;
        if (net_done) begin
          in_flight = 1'b0;
          check("spikes_in_stable", {63'd0, stable_bad}, 64'd0);
        end
      end
      prev_start = net_start;
      if (result_err && !prev_err) err_delta = cyc - last_start_cyc;
      prev_err = result_err;
      if (result_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got result_valid, expected none");
        end else begin
          e = exp_q.pop_front();
          check("result_counts", 64'(result_counts), 64'(e.counts));
          check("result_class", 64'(result_class), 64'(e.cls));
          check("result_err", 64'(result_err), 64'(e.err));
          check("net_start_count", 64'(starts), 64'(e.starts));
          check("net_start_single", {63'd0, dbl_start}, 64'd0);
          check("busy_at_result", {63'd0, busy}, 64'd0);
        end
        starts = 0;
        dbl_start = 1'b0;
      end
      prev_valid = result_valid;
    end
  end

  task automatic push_exp(input logic [N_OUT*CNT_W-1:0] c, input logic [2:0] cl,
                          input logic er, input int st);
    exp_t x;
    x.counts = c; x.cls = cl; x.err = er; x.starts = st;
    exp_q.push_back(x);
  endtask

  task automatic start_run(input int n);
    @(negedge clk);
    num_steps = STEP_W'(n);
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_result(input string name, input int budget);
    int k = 0;
    while (!result_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!result_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no result_valid in %0d cycles, expected result", name, budget);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic load_test1_ram();
    for (int i = 0; i < 256; i++) ram[i] = '0;
    ram[0] = 30'h1; ram[1] = 30'h2; ram[2] = 30'h1; ram[3] = 30'h0;
  endtask

  initial begin
    int k;
    cmd_start = 1'b0;
    num_steps = '0;
    load_test1_ram();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_result_valid", {63'd0, result_valid}, 64'd0);
    check("rst_result_err", {63'd0, result_err}, 64'd0);
    check("rst_result_counts", 64'(result_counts), 64'd0);
    check("rst_net_start", {63'd0, net_start}, 64'd0);
    check("rst_stim_rd_en", {63'd0, stim_rd_en}, 64'd0);
    rst = 1'b0;

    // Test 1: echo network, counts [2,1,0,0,0]
    net_mode = 1'b0; net_lat = 2;
    push_exp(20'h00012, 3'd0, 1'b0, 4);
    start_run(4);
    wait_result("t1", 200);

    // Test 2: tie between class 1 and 2; mid-run cmd_start and num_steps change ignored
    net_mode = 1'b1; net_pat = 5'b00110; net_lat = 1;
    push_exp(20'h00330, 3'd1, 1'b0, 3);
    start_run(3);
    repeat (4) @(negedge clk);
    num_steps = 8'd7;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    wait_result("t2", 200);
    check("t2_result_held", {63'd0, result_valid}, 64'd1);

    // Test 3: saturation of class 4 over 255 steps
    net_pat = 5'b10000;
    push_exp(20'hF0000, 3'd4, 1'b0, 255);
    start_run(255);
    wait_result("t3", 4000);

    // Test 7: echo pattern where class 3 wins
    net_mode = 1'b0;
    ram[0] = 30'h08; ram[1] = 30'h0A; ram[2] = 30'h08;
    push_exp(20'h03010, 3'd3, 1'b0, 3);
    start_run(3);
    wait_result("t7", 200);

    // Test 4: network stops answering after 2 steps -> watchdog abort
    net_mode = 1'b1; net_pat = 5'b00001; resp_limit = 2;
    err_delta = -1;
    push_exp(20'h00002, 3'd0, 1'b1, 3);
    start_run(5);
    wait_result("t4", 4000);
    // 2**TMO_W-1 WAIT cycles, then the error flag registers on the next edge
    check("t4_err_latency", 64'(err_delta), 64'(1 << TMO_W));
    resp_limit = 1000;

    // Test 5: zero-step run, result two cycles after cmd_start
    push_exp(20'h0, 3'd0, 1'b0, 0);
    @(negedge clk);
    num_steps = '0;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    check("t5_valid_cycle1", {63'd0, result_valid}, 64'd0);
    @(negedge clk);
    check("t5_valid_cycle2", {63'd0, result_valid}, 64'd1);
    @(negedge clk);

    // Test 6: asynchronous reset in the middle of a WAIT
    net_mode = 1'b0; net_lat = 3;
    for (int i = 0; i < 10; i++) ram[i] = 30'h15;
    start_run(10);
    k = 0;
    while (starts < 3 && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("t6_busy_before_rst", {63'd0, busy}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_busy", {63'd0, busy}, 64'd0);
    check("t6_rst_spikes_in", 64'(net_spikes_in), 64'd0);
    check("t6_rst_stim_addr", 64'(stim_addr), 64'd0);
    check("t6_rst_net_start", {63'd0, net_start}, 64'd0);
    check("t6_rst_stim_rd_en", {63'd0, stim_rd_en}, 64'd0);
    check("t6_rst_result_valid", {63'd0, result_valid}, 64'd0);
    check("t6_rst_result_counts", 64'(result_counts), 64'd0);
    check("t6_rst_result_class", 64'(result_class), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Fresh run after reset reproduces test 1
    load_test1_ram();
    net_lat = 2;
    push_exp(20'h00012, 3'd0, 1'b0, 4);
    start_run(4);
    wait_result("t6_rerun", 200);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
